// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit for the execute stage.
// Multiplies and accumulates finish in one cycle; divides use a 32-step restoring FSM.

`ifndef AluOp_Mult
`define AluOp_Mult   5'd16
`define AluOp_Multu  5'd17
`define AluOp_Madd   5'd18
`define AluOp_Maddu  5'd19
`define AluOp_Msub   5'd20
`define AluOp_Msubu  5'd21
`define AluOp_Div    5'd22
`define AluOp_Divu   5'd23
`define AluOp_Mthi   5'd24
`define AluOp_Mtlo   5'd25
`define AluOp_Mfhi   5'd26
`define AluOp_Mflo   5'd27
`endif

module hilo_muldiv #(
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        OpValid,
  input  logic [4:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Kill,
  output logic        Stall,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Result
);

  localparam int         DIV_ITER = 32;
  localparam logic [4:0] LAST_CNT = 5'(DIV_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        is_hilo;
  logic        is_div;
  logic        div_signed;
  logic        busy;
  logic        accept;
  logic        start_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  always_comb begin
    is_hilo = 1'b0;
    case (ALUOp)
      `AluOp_Mult, `AluOp_Multu, `AluOp_Madd, `AluOp_Maddu,
      `AluOp_Msub, `AluOp_Msubu, `AluOp_Div, `AluOp_Divu,
      `AluOp_Mthi, `AluOp_Mtlo, `AluOp_Mfhi, `AluOp_Mflo: is_hilo = 1'b1;
      default: is_hilo = 1'b0;
    endcase
  end

  assign is_div     = (ALUOp == `AluOp_Div) || (ALUOp == `AluOp_Divu);
  assign div_signed = (ALUOp == `AluOp_Div);
  assign accept     = OpValid & is_hilo & ~busy & ~Kill;
  assign start_div  = accept & is_div;

  // Low 64 bits of a 64x64 product equal the signed 32x32 product when operands are sign-extended.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign acc    = {hi_q, lo_q};

  assign a_mag = (div_signed && A[31]) ? (32'd0 - A) : A;
  assign b_mag = (div_signed && B[31]) ? (32'd0 - B) : B;

  // Dividend sits in quo_q and shifts out MSB-first while quotient bits shift in.
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, dvsr_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_div) state_d = S_ITER;
      S_ITER: begin
        if (Kill) begin
          state_d = S_IDLE;
        end else if (count_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    Busy   = busy;
    Stall  = OpValid & is_hilo & busy;
    Result = 32'd0;
    if (ALUOp == `AluOp_Mfhi) begin
      Result = hi_q;
    end else if (ALUOp == `AluOp_Mflo) begin
      Result = lo_q;
    end
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      S_ITER: begin
        count_d = count_q + 5'd1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      S_FIX: begin
        if (!Kill) begin
          lo_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
          hi_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        end
      end
      default: ;
    endcase

    // Accept only happens in IDLE, so it never collides with the FIX write.
    if (accept) begin
      case (ALUOp)
        `AluOp_Mult:  {hi_d, lo_d} = prod_s;
        `AluOp_Multu: {hi_d, lo_d} = prod_u;
        `AluOp_Madd:  {hi_d, lo_d} = acc + prod_s;
        `AluOp_Maddu: {hi_d, lo_d} = acc + prod_u;
        `AluOp_Msub:  {hi_d, lo_d} = acc - prod_s;
        `AluOp_Msubu: {hi_d, lo_d} = acc - prod_u;
        `AluOp_Mthi:  hi_d = A;
        `AluOp_Mtlo:  lo_d = A;
        `AluOp_Div, `AluOp_Divu: begin
          rem_d     = 32'd0;
          quo_d     = a_mag;
          dvsr_d    = b_mag;
          count_d   = 5'd0;
          neg_quo_d = div_signed & (A[31] ^ B[31]);
          neg_rem_d = div_signed & A[31];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q      <= HILO_RESET;
      lo_q      <= HILO_RESET;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      count_q   <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic reference model.
// One line is printed per accepted transaction.

`ifndef AluOp_Mult
`define AluOp_Mult   5'd16
`define AluOp_Multu  5'd17
`define AluOp_Madd   5'd18
`define AluOp_Maddu  5'd19
`define AluOp_Msub   5'd20
`define AluOp_Msubu  5'd21
`define AluOp_Div    5'd22
`define AluOp_Divu   5'd23
`define AluOp_Mthi   5'd24
`define AluOp_Mtlo   5'd25
`define AluOp_Mfhi   5'd26
`define AluOp_Mflo   5'd27
`endif

module tb_hilo_muldiv;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        OpValid = 1'b0;
  logic [4:0]  ALUOp = 5'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Kill = 1'b0;
  logic        Stall;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural HI/LO plus a pending divide result and its remaining cycles.
  logic [31:0] m_hi, m_lo, m_pq, m_pr;
  int          m_rem;

  logic        last_stall;
  logic [31:0] last_result;

  hilo_muldiv #(.HILO_RESET(32'h0)) dut (
    .clock  (clock),
    .reset  (reset),
    .OpValid(OpValid),
    .ALUOp  (ALUOp),
    .A      (A),
    .B      (B),
    .Kill   (Kill),
    .Stall  (Stall),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .Result (Result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_hilo_op(input logic [4:0] op);
    case (op)
      `AluOp_Mult, `AluOp_Multu, `AluOp_Madd, `AluOp_Maddu,
      `AluOp_Msub, `AluOp_Msubu, `AluOp_Div, `AluOp_Divu,
      `AluOp_Mthi, `AluOp_Mtlo, `AluOp_Mfhi, `AluOp_Mflo: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input logic v, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic k);
    logic [63:0] acc, smul, umul;
    int sa, sb;
    acc  = {m_hi, m_lo};
    smul = 64'(longint'($signed(a)) * longint'($signed(b)));
    umul = {32'd0, a} * {32'd0, b};
    sa   = $signed(a);
    sb   = $signed(b);
    if (m_rem > 0) begin
      if (k) begin
        m_rem = 0;
        $display("t=%0t kill pending divide", $time);
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_lo = m_pq;
          m_hi = m_pr;
          $display("t=%0t divide done hi=%h lo=%h", $time, m_hi, m_lo);
        end
      end
    end else if (v && is_hilo_op(op) && !k) begin
      case (op)
        `AluOp_Mult:  {m_hi, m_lo} = smul;
        `AluOp_Multu: {m_hi, m_lo} = umul;
        `AluOp_Madd:  {m_hi, m_lo} = acc + smul;
        `AluOp_Maddu: {m_hi, m_lo} = acc + umul;
        `AluOp_Msub:  {m_hi, m_lo} = acc - smul;
        `AluOp_Msubu: {m_hi, m_lo} = acc - umul;
        `AluOp_Mthi:  m_hi = a;
        `AluOp_Mtlo:  m_lo = a;
        `AluOp_Divu: begin
          if (b == 0) begin
            m_pq = 32'hFFFFFFFF; m_pr = a;
          end else begin
            m_pq = a / b; m_pr = a % b;
          end
          m_rem = 33;
        end
        `AluOp_Div: begin
          if (b == 0) begin
            m_pq = a[31] ? 32'h1 : 32'hFFFFFFFF; m_pr = a;
          end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            m_pq = 32'h80000000; m_pr = 32'h0;
          end else begin
            m_pq = 32'(sa / sb); m_pr = 32'(sa % sb);
          end
          m_rem = 33;
        end
        default: ;
      endcase
      $display("t=%0t op=%0d a=%h b=%h -> hi=%h lo=%h", $time, op, a, b, m_hi, m_lo);
    end
  endtask

  // Called at a falling edge; drives one cycle, checks outputs mid-cycle, steps the model at the rising edge.
  task automatic cycle(input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic k);
    logic [31:0] exp_res;
    OpValid = v; ALUOp = op; A = a; B = b; Kill = k;
    #1;
    exp_res = (op == `AluOp_Mfhi) ? m_hi : (op == `AluOp_Mflo) ? m_lo : 32'd0;
    check("stall",  Stall,  64'(v & is_hilo_op(op) & (m_rem > 0)));
    check("busy",   Busy,   64'(m_rem > 0));
    check("result", Result, exp_res);
    check("hi",     HI,     m_hi);
    check("lo",     LO,     m_lo);
    last_stall  = Stall;
    last_result = Result;
    @(posedge clock);
    model_edge(v, op, a, b, k);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; OpValid = 1'b0; Kill = 1'b0; ALUOp = 5'd0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
    check("rst_busy",  Busy,  0);
    check("rst_stall", Stall, 0);
    check("rst_hi",    HI,    0);
    check("rst_lo",    LO,    0);
    $display("t=%0t reset", $time);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12) return 5'(16 + r);
    return 5'($urandom_range(0, 15));
  endfunction

  initial begin
    int n;
    m_hi = 0; m_lo = 0; m_rem = 0; m_pq = 0; m_pr = 0;
    do_reset();

    // Signed vs unsigned multiply
    cycle(1'b1, `AluOp_Mult, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFE);
    cycle(1'b1, `AluOp_Multu, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_hi", HI, 32'h1);
    check("multu_lo", LO, 32'hFFFFFFFE);

    // Accumulate with carry across LO/HI, then subtract back
    cycle(1'b1, `AluOp_Mthi, 32'd5, 32'd0, 1'b0);
    cycle(1'b1, `AluOp_Mtlo, 32'hFFFFFFFF, 32'd0, 1'b0);
    cycle(1'b1, `AluOp_Maddu, 32'd1, 32'd1, 1'b0);
    check("maddu_hi", HI, 32'd6);
    check("maddu_lo", LO, 32'd0);
    cycle(1'b1, `AluOp_Msub, 32'd1, 32'd1, 1'b0);
    check("msub_hi", HI, 32'd5);
    check("msub_lo", LO, 32'hFFFFFFFF);

    // Signed divide with a back-to-back Mflo that must stall for the whole divide
    cycle(1'b1, `AluOp_Div, 32'hFFFFFFF9, 32'd2, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, `AluOp_Mflo, 32'd0, 32'd0, 1'b0);
      if (!last_stall) break;
      n++;
    end
    check("div_stall_cycles", n, 33);
    check("div_mflo_result", last_result, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    // Divide-by-zero and overflow corners
    cycle(1'b1, `AluOp_Divu, 32'd9, 32'd0, 1'b0);
    idle(33);
    check("divu0_lo", LO, 32'hFFFFFFFF);
    check("divu0_hi", HI, 32'd9);
    cycle(1'b1, `AluOp_Div, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(33);
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'd0);
    cycle(1'b1, `AluOp_Div, 32'hFFFFFFF9, 32'd0, 1'b0);
    idle(33);
    check("div0neg_lo", LO, 32'h1);
    check("div0neg_hi", HI, 32'hFFFFFFF9);

    // Kill mid-divide leaves HI/LO alone; a later divide completes normally
    cycle(1'b1, `AluOp_Mthi, 32'h0, 32'd0, 1'b0);
    cycle(1'b1, `AluOp_Mtlo, 32'h80000000, 32'd0, 1'b0);
    cycle(1'b1, `AluOp_Div, 32'd100, 32'd7, 1'b0);
    idle(19);
    cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    check("kill_busy", Busy, 0);
    check("kill_hi", HI, 32'h0);
    check("kill_lo", LO, 32'h80000000);
    cycle(1'b1, `AluOp_Divu, 32'd100, 32'd7, 1'b0);
    idle(33);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // Reset in the middle of a divide
    cycle(1'b1, `AluOp_Mthi, 32'h1234, 32'd0, 1'b0);
    cycle(1'b1, `AluOp_Div, 32'd1000, 32'd3, 1'b0);
    idle(10);
    do_reset();
    cycle(1'b1, `AluOp_Mfhi, 32'd0, 32'd0, 1'b0);
    check("rst_mfhi", last_result, 32'd0);
    check("rst_busy_after", Busy, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 4) != 0), rand_op(), rand_opnd(), rand_opnd(),
              ($urandom_range(0, 31) == 0));
      end
    end
    idle(35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
